// File: rtl/sipo_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Brief    : Shared types and helpers for the serial-in parallel-out
//            deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Receive-side states of the deserializer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // no bits collected yet
    SHIFT = 2'd1,   // partial word in progress
    PEND  = 2'd2    // full word parked in the shift register
  } state_t;

  // Width of a counter that must be able to hold values 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_deser_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deser_if
// Brief    : Serial input / valid-ready parallel output bundle of the
//            deserializer. master = stream source and word sink,
//            slave = deserializer.
// Revision : 1.0 - initial release
// ============================================================================
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             si;
  logic             si_valid;
  logic             si_abort;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;

  modport master (
    output si, si_valid, si_abort, po_ready,
    input  po, po_valid
  );

  modport slave (
    input  si, si_valid, si_abort, po_ready,
    output po, po_valid
  );
endinterface
`default_nettype wire

// File: rtl/sipo_deser_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_out_reg
// Brief    : Single-entry valid/ready holding register for completed words.
//            The caller only asserts load_i when the entry is free or is
//            being drained on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             ready_i,
  output logic      [WIDTH-1:0] po_o,
  output logic                  po_valid_o
);

  logic [WIDTH-1:0] po_q;
  logic             valid_q;

  // Load wins over drain so back-to-back words leave no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      po_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      po_q    <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign po_o       = po_q;
  assign po_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deser
// Brief    : Serial-in parallel-out deserializer. Collects qualified bits
//            into WIDTH-bit words, parks one finished word while the output
//            is stalled and flags overrun on bits that arrive meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  sipo_deser_if.slave bus,
  output logic        busy_o,
  output logic        overrun_o,
  input  wire logic   overrun_clr_i
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;

  logic [WIDTH-1:0] shift_in;
  logic             out_free;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Shift direction decides which end of the word the first bit reaches
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_in = {shift_q[WIDTH-2:0], bus.si};
    end else begin : g_lsb_first
      assign shift_in = {bus.si, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // Output entry can take a word if empty or being drained this edge
  assign out_free = !bus.po_valid || bus.po_ready;

  // Next-state logic: bit collection, word hand-off, abort and overrun
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_word = shift_in;
    overrun_d = overrun_clr_i ? 1'b0 : overrun_q;

    case (state_q)
      IDLE, SHIFT: begin
        if (bus.si_abort) begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end else if (bus.si_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (out_free) begin
              load      = 1'b1;
              load_word = shift_in;
              shift_d   = '0;
              state_d   = IDLE;
            end else begin
              shift_d = shift_in;
              state_d = PEND;
            end
          end else begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
            state_d = SHIFT;
          end
        end
      end

      PEND: begin
        // No room for a new bit while a finished word is parked
        if (bus.si_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.si_abort) begin
          shift_d = '0;
          state_d = IDLE;
        end else if (bus.po_ready) begin
          load      = 1'b1;
          load_word = shift_q;
          shift_d   = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .data_i     (load_word),
    .ready_i    (bus.po_ready),
    .po_o       (bus.po),
    .po_valid_o (bus.po_valid)
  );

  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deser
// Brief    : Scoreboard bench driving an MSB-first and an LSB-first
//            deserializer with the same serial stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, si, si_valid, si_abort, po_ready, overrun_clr;
  logic busy_m, busy_l, ovr_m, ovr_l;

  sipo_deser_if #(.WIDTH(4)) if_m ();
  sipo_deser_if #(.WIDTH(4)) if_l ();

  assign if_m.si       = si;
  assign if_m.si_valid = si_valid;
  assign if_m.si_abort = si_abort;
  assign if_m.po_ready = po_ready;
  assign if_l.si       = si;
  assign if_l.si_valid = si_valid;
  assign if_l.si_abort = si_abort;
  assign if_l.po_ready = po_ready;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk           (clk),
    .rst           (rst),
    .bus           (if_m),
    .busy_o        (busy_m),
    .overrun_o     (ovr_m),
    .overrun_clr_i (overrun_clr)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk           (clk),
    .rst           (rst),
    .bus           (if_l),
    .busy_o        (busy_l),
    .overrun_o     (ovr_l),
    .overrun_clr_i (overrun_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] qm[$];
  logic [3:0] ql[$];
  logic       stall_m = 1'b0, stall_l = 1'b0;
  logic [3:0] hold_m = '0, hold_l = '0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input logic [7:0] am, input logic [7:0] al,
                        input logic [7:0] exp);
    check({name, "_msb"}, am, exp);
    check({name, "_lsb"}, al, exp);
  endtask

  task automatic push(input logic [3:0] wm, input logic [3:0] wl);
    qm.push_back(wm);
    ql.push_back(wl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    si       = b;
    si_valid = 1'b1;
    tick();
    si_valid = 1'b0;
    si       = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  // MSB-first monitor: pops on every transfer, checks hold while stalled
  always @(negedge clk) begin
    if (rst) begin
      stall_m = 1'b0;
    end else begin
      if (stall_m)
        check("m_stall_hold", {3'b0, if_m.po_valid, if_m.po}, {4'b0001, hold_m});
      if (if_m.po_valid && po_ready) begin
        if (qm.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m_unexpected_word: got %0h expected no word", if_m.po);
        end else begin
          check("m_word", {4'b0, if_m.po}, {4'b0, qm.pop_front()});
        end
      end
      stall_m = if_m.po_valid && !po_ready;
      hold_m  = if_m.po;
    end
  end

  // LSB-first monitor
  always @(negedge clk) begin
    if (rst) begin
      stall_l = 1'b0;
    end else begin
      if (stall_l)
        check("l_stall_hold", {3'b0, if_l.po_valid, if_l.po}, {4'b0001, hold_l});
      if (if_l.po_valid && po_ready) begin
        if (ql.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL l_unexpected_word: got %0h expected no word", if_l.po);
        end else begin
          check("l_word", {4'b0, if_l.po}, {4'b0, ql.pop_front()});
        end
      end
      stall_l = if_l.po_valid && !po_ready;
      hold_l  = if_l.po;
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; si = 1'b0; si_valid = 1'b0; si_abort = 1'b0;
    po_ready = 1'b1; overrun_clr = 1'b0;
    idle(2);
    check2("rst_po", if_m.po, if_l.po, 8'h0);
    check2("rst_valid", if_m.po_valid, if_l.po_valid, 8'h0);
    check2("rst_busy", busy_m, busy_l, 8'h0);
    check2("rst_ovr", ovr_m, ovr_l, 8'h0);
    rst = 1'b0;
    idle(1);

    // 1011 back-to-back: latency and single-cycle valid
    push(4'b1011, 4'b1101);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check2("t1_no_early_valid", if_m.po_valid, if_l.po_valid, 8'h0);
    send_bit(1'b1);
    check2("t1_valid", if_m.po_valid, if_l.po_valid, 8'h1);
    check("t1_po_msb", if_m.po, 8'hB);
    check("t1_po_lsb", if_l.po, 8'hD);
    tick();
    check2("t1_valid_drop", if_m.po_valid, if_l.po_valid, 8'h0);

    // Stall: one word in output, second parked, extra bit overruns
    po_ready = 1'b0;
    push(4'b1011, 4'b1101);
    push(4'b0110, 4'b0110);
    send_word(4'b1011);
    send_word(4'b0110);
    idle(2);
    check2("t3_busy_pend", busy_m, busy_l, 8'h1);
    check("t3_po_held", if_m.po, 8'hB);
    check2("t3_ovr_clear", ovr_m, ovr_l, 8'h0);
    send_bit(1'b1);
    check2("t3_ovr_set", ovr_m, ovr_l, 8'h1);
    po_ready = 1'b1;
    tick();
    check("t3_second_msb", if_m.po, 8'h6);
    check2("t3_valid_kept", if_m.po_valid, if_l.po_valid, 8'h1);
    check2("t3_idle", busy_m, busy_l, 8'h0);
    tick();
    check2("t3_drained", if_m.po_valid, if_l.po_valid, 8'h0);
    check2("t3_ovr_sticky", ovr_m, ovr_l, 8'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check2("t3_ovr_cleared", ovr_m, ovr_l, 8'h0);

    // Abort after two bits, abort beats simultaneous si_valid
    push(4'b0010, 4'b0100);
    send_bit(1'b1); send_bit(1'b1);
    si = 1'b1; si_valid = 1'b1; si_abort = 1'b1;
    tick();
    si = 1'b0; si_valid = 1'b0; si_abort = 1'b0;
    check2("t4_abort_idle", busy_m, busy_l, 8'h0);
    send_word(4'b0010);
    idle(1);

    // Gapped bits
    begin
      logic [3:0] w;
      w = 4'b1001;
      push(4'b1001, 4'b1001);
      for (int i = 3; i >= 0; i--) begin
        send_bit(w[i]);
        if (i != 0) begin
          idle(3);
          check2("t5_no_early", if_m.po_valid, if_l.po_valid, 8'h0);
        end
      end
      check2("t5_valid", if_m.po_valid, if_l.po_valid, 8'h1);
      idle(1);
    end

    // Reset mid-word with valid and overrun set
    po_ready = 1'b0;
    push(4'b1100, 4'b0011);
    send_word(4'b1100);
    send_word(4'b0000);
    send_bit(1'b1);
    po_ready = 1'b1;
    tick();
    po_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0);
    check2("t6_pre_valid", if_m.po_valid, if_l.po_valid, 8'h1);
    check2("t6_pre_ovr", ovr_m, ovr_l, 8'h1);
    check2("t6_pre_busy", busy_m, busy_l, 8'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check2("t6_rst_po", if_m.po, if_l.po, 8'h0);
    check2("t6_rst_valid", if_m.po_valid, if_l.po_valid, 8'h0);
    check2("t6_rst_ovr", ovr_m, ovr_l, 8'h0);
    check2("t6_rst_busy", busy_m, busy_l, 8'h0);
    po_ready = 1'b1;
    push(4'b0101, 4'b1010);
    send_word(4'b0101);
    check("t6_po_msb", if_m.po, 8'h5);
    check("t6_po_lsb", if_l.po, 8'hA);

    for (int i = 0; i < 20 && (qm.size() + ql.size()) > 0; i++) tick();
    idle(2);
    check("drain_msb", qm.size(), 8'h0);
    check("drain_lsb", ql.size(), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in parallel-out deserializer. It is the receive-side counterpart of the team's 4-bit PISO transmitter.
- Collects qualified serial bits MSB-first into a WIDTH-bit word.
- Presents each completed word on a valid/ready output port.
- Holds one completed word pending while the output is stalled, and flags overrun when more bits arrive.

Parameters:
- WIDTH, 4, number of bits per word (must be >= 2)
- MSB_FIRST, 1, 1 = first received bit lands in po[WIDTH-1]; 0 = first received bit lands in po[0]

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- si  in  1  serial data bit
- si_valid  in  1  si is sampled on this edge when 1
- si_abort  in  1  discard the partial word in progress
- po  out  WIDTH  parallel output word
- po_valid  out  1  po holds an undelivered word
- po_ready  in  1  downstream accepts po this cycle when po_valid=1
- busy  out  1  partial word in progress (bit count != 0) or word pending
- overrun  out  1  sticky: a bit was dropped while a word was pending
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (rst=1 at edge): state=IDLE, shift reg=0, bit count=0, po=0, po_valid=0, overrun=0, busy=0. Reset mid-word drops all partial and pending data.
- States:
  - IDLE: count=0.
  - SHIFT: 0 < count < WIDTH.
  - PEND: a full word is held in the shift register while the output register is occupied.
- Bit accept, in IDLE or SHIFT with si_valid=1:
  - MSB_FIRST=1: shift <= {shift[WIDTH-2:0], si}.
  - MSB_FIRST=0: shift <= {si, shift[WIDTH-1:1]}.
  - count increments.
- Word completion, on the edge accepting bit number WIDTH:
  - If the output is free (po_valid=0, or po_valid&&po_ready on the same edge): po <= completed word (including the current si), po_valid=1 from the next cycle, count=0, state=IDLE.
  - Otherwise: state=PEND, completed word held in the shift register.
  - Latency: po_valid rises 1 cycle after the edge that samples the last bit.
- Back-to-back words: a word may complete on the same edge the previous word is accepted. po_valid stays 1 and po updates. There are no idle bubbles.
- PEND:
  - On the edge with po_ready=1, po <= pending word; po_valid stays 1; state=IDLE; count=0.
  - si_valid=1 while in PEND, including the edge that leaves PEND: the bit is dropped and overrun <= 1.
- Output handshake: po and po_valid are stable while po_valid=1 and po_ready=0. po_valid clears on a po_ready edge only if no new word is loaded on that edge.
- si_abort=1 (not PEND): count=0, shift=0, state=IDLE.
  - Abort wins over a simultaneous si_valid; that bit is discarded.
  - No effect on po, po_valid or overrun.
  - In PEND, abort discards the pending word and returns to IDLE.
- overrun: set has priority over overrun_clr on the same edge.
- Count width: $clog2(WIDTH+1). Count never exceeds WIDTH-1 when registered.
- busy = (state != IDLE).

Decomposition:
- Shared package sipo_pkg: state enum (IDLE, SHIFT, PEND) and function cnt_width(WIDTH).
- One natural sub-module: sipo_out_reg, the single-entry valid/ready holding register (load, ready, po, po_valid).
- The top module contains the shift register, bit counter, FSM and overrun flag.

Test Plan:
- WIDTH=4, MSB_FIRST=1, po_ready=1, bits 1,0,1,1 on consecutive cycles -> po=4'b1011, po_valid=1 for exactly 1 cycle, one cycle after the 4th bit edge.
- MSB_FIRST=0, same bits 1,0,1,1 -> po=4'b1101.
- po_ready=0; send 1011 then 0110 -> first word held stable; state PEND, busy=1. Raise po_ready -> 1011 delivered, then 0110, overrun=0. A further bit while PEND -> overrun=1, persists until overrun_clr.
- Send bits 1,1, then si_abort with si_valid=1, then 0,0,1,0 -> po=4'b0010, no trace of the aborted bits.
- si_valid gapped (bit, 3 idle cycles, bit, ...) sending 1001 -> po=4'b1001, identical result to the back-to-back case.
- Assert rst after 2 bits with po_valid=1 and overrun=1 -> next cycle all outputs 0. Then 0101 -> po=4'b0101.
